// File: rtl/bit_enum_if.sv
// Handshake bundle for bit_enum: vector input side and per-index output side.
// The design attaches through the slave modport; the driving environment uses master.
interface bit_enum_if #(
    parameter int W = 8
);
    logic                   in_vld;
    logic [W-1:0]           in_x;
    logic                   in_rdy;
    logic                   out_vld;
    logic [$clog2(W)-1:0]   out_idx;
    logic [$clog2(W):0]     out_cnt;
    logic                   out_last;
    logic                   out_rdy;
    logic                   drop;

    modport slave (
        input  in_vld, in_x, out_rdy,
        output in_rdy, out_vld, out_idx, out_cnt, out_last, drop
    );

    modport master (
        output in_vld, in_x, out_rdy,
        input  in_rdy, out_vld, out_idx, out_cnt, out_last, drop
    );
endinterface

// File: rtl/bit_enum.sv
// Set-bit enumerator: accepts a W-bit vector and emits the index of each set bit,
// lowest first, one per accepted output beat, with a running 1-based ordinal.
module bit_enum #(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    bit_enum_if.slave   bus
);
    localparam int IW = $clog2(W);
    localparam int CW = IW + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_res;
    logic [W-1:0]   w_res_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [IW-1:0]  r_idx;
    logic           r_last;
    logic           r_drop;
    logic           w_drop_nxt;
    logic           w_out_vld;
    logic           w_out_fire;
    logic           w_in_rdy;
    logic           w_in_fire;
    logic           w_in_zero;

    function automatic logic [IW-1:0] lsb_idx(input logic [W-1:0] x);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_one_hot(input logic [W-1:0] x);
        return (x != {W{1'b0}}) && ((x & (x - W'(1))) == {W{1'b0}});
    endfunction

    assign w_out_vld  = (r_state == ST_EMIT);
    assign w_out_fire = w_out_vld & bus.out_rdy;
    // A finishing last beat frees the slot in the same cycle, so vectors stream without a bubble.
    assign w_in_rdy   = (r_state == ST_IDLE) | (w_out_fire & r_last);
    assign w_in_fire  = bus.in_vld & w_in_rdy;
    assign w_in_zero  = (bus.in_x == {W{1'b0}});

    assign bus.in_rdy   = w_in_rdy;
    assign bus.out_vld  = w_out_vld;
    assign bus.out_idx  = r_idx;
    assign bus.out_cnt  = r_cnt;
    assign bus.out_last = r_last;
    assign bus.drop     = r_drop;

    // Next-state, residual, ordinal and drop decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_drop_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire && !w_in_zero) begin
                    w_res_nxt   = bus.in_x;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_drop_nxt  = w_in_fire;
                end
            end
            ST_EMIT: begin
                if (w_out_fire && !r_last) begin
                    w_res_nxt = r_res & (r_res - W'(1));
                    w_cnt_nxt = r_cnt + CW'(1);
                end else if (w_out_fire) begin
                    if (w_in_fire && !w_in_zero) begin
                        w_res_nxt   = bus.in_x;
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = ST_EMIT;
                    end else begin
                        w_res_nxt   = {W{1'b0}};
                        w_state_nxt = ST_IDLE;
                        w_drop_nxt  = w_in_fire;
                    end
                end else begin
                    w_res_nxt = r_res;
                end
            end
            default: begin
                w_res_nxt   = {W{1'b0}};
                w_cnt_nxt   = {CW{1'b0}};
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered output fields; idx/last are precomputed from the next residual.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_res   <= {W{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_idx   <= {IW{1'b0}};
            r_last  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_res   <= w_res_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= lsb_idx(w_res_nxt);
            r_last  <= is_one_hot(w_res_nxt);
            r_drop  <= w_drop_nxt;
        end
    end
endmodule

// File: doc/bit_enum.md
# bit_enum

Sequential set-bit enumerator: accepts a W-bit vector over a valid/ready handshake and emits the index of each set bit, one per cycle, LSB first, over a second valid/ready handshake. The running ordinal `out_cnt` on the final beat equals the vector's population count. It sits on the producer side of the team's popcount path and expands a mask into individual events (per-lane grants, per-bit work items) instead of summing it.

## Interface
- `W`, default 8: input vector width. Legal range is W ≥ 2.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_vld`  in  1  an input vector is offered.
- `in_x`  in  W  the vector to enumerate.
- `in_rdy`  out  1  the block can accept a vector this cycle.
- `out_vld`  out  1  an index beat is presented.
- `out_idx`  out  $clog2(W)  bit position of the current set bit.
- `out_cnt`  out  $clog2(W)+1  1-based ordinal of the current beat within its vector.
- `out_last`  out  1  the current beat is the highest set bit of the vector.
- `out_rdy`  in  1  the consumer accepts the beat.
- `drop`  out  1  single-cycle pulse: an all-zero vector was accepted and discarded.

## Operation
- States:
  - IDLE: no residual.
  - EMIT: the residual register `r` is non-zero.
- Input handshake fires when `in_vld & in_rdy`.
  - `in_rdy` = (state == IDLE) | (out_vld & out_rdy & out_last).
  - Back-to-back vectors therefore stream with no bubble.
- Accepting a non-zero `in_x`:
  - `r` ← `in_x`, `cnt` ← 1, next state EMIT.
- Accepting an all-zero `in_x`:
  - Nothing is emitted; `drop` ← 1 for the next cycle.
  - State becomes or stays IDLE.
  - If this handshake coincides with a last-beat handshake, the state goes to IDLE.
- In EMIT:
  - `out_vld` = 1.
  - `out_idx` = index of the lowest set bit of `r`.
  - `out_last` = (`r` has exactly one bit set).
  - `out_cnt` = `cnt`.
- Output handshake, when `out_vld & out_rdy`:
  - Not last: `r` ← r & (r − 1) (clear the lowest set bit), `cnt` ← cnt + 1.
  - Last, with no simultaneous input handshake: `r` ← 0, state ← IDLE.
  - Last, with a simultaneous non-zero input handshake: load the new vector as above and stay in EMIT.
- Backpressure: while `out_vld & !out_rdy`, `out_idx`, `out_cnt` and `out_last` hold stable, and `in_x` is not sampled.
- Arithmetic: `cnt` never exceeds W, so the width $clog2(W)+1 never wraps. The all-ones vector yields `out_cnt` = W on the last beat.
- `in_x` is ignored whenever `in_rdy` = 0. The input side must hold `in_vld` and `in_x` until accepted. The block does not check this.

## Timing
- Reset values (asynchronous on `rst_n` low, held until release):
  - state IDLE, `r` = 0, `cnt` = 0.
  - `out_vld` = 0, `out_last` = 0, `out_idx` = 0, `out_cnt` = 0, `drop` = 0.
  - `in_rdy` = 1.
- Reset asserted mid-vector: the remaining beats are discarded. After release the block is in IDLE and no beat is replayed.
- Latency: a vector accepted on edge N presents its first beat in the cycle after edge N.
- A vector with k set bits occupies exactly k output cycles when `out_rdy` is held high.
- Sustained throughput with `out_rdy` = 1 and back-to-back input is one index per cycle.
- `drop` asserts in the cycle after the zero-vector handshake, for exactly one cycle.
- Combinational paths:
  - `in_rdy` depends combinationally on `out_rdy`.
  - `out_*` are functions of registered state only; there is no path from `in_*` to `out_*`.

## Test plan
- W=8, in_x=8'b1010_0100, out_rdy=1 -> three beats on consecutive cycles:
  - beat 1: idx 2, cnt 1, last 0.
  - beat 2: idx 5, cnt 2, last 0.
  - beat 3: idx 7, cnt 3, last 1.
  - `in_rdy` high during beat 3.
- Back-to-back 8'h81 then 8'h02, in_vld continuous -> idx 0, 7(last), 1(last) on three consecutive cycles, no bubble.
- in_x=8'h00 -> no `out_vld`; `drop` is a one-cycle pulse one cycle after acceptance; `in_rdy` stays 1.
- in_x=8'hFF with out_rdy toggled 1,0,0,1,… -> idx 0..7 in order, each held stable while stalled; last beat has cnt 8.
- Reset asserted after the second beat of 8'hF0 -> outputs return to reset values immediately; after release `in_rdy`=1, no residual beats; the next vector 8'h08 yields a single beat idx 3, cnt 1, last 1.
- Random vectors with random out_rdy over 10k cycles -> the emitted index sets match the inputs bit-for-bit, and the last `out_cnt` of each vector equals the popcount reference.
